// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, ALU opcodes and forwarding-select encodings for the EX stage
package mips_pkg;
  localparam int DW = 8;
  localparam int IW = 19;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_NOP = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;
  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  function automatic logic [DW-1:0] fwd_mux(input logic [1:0] sel, input logic [DW-1:0] reg_val,
                                            input logic [DW-1:0] exmem, input logic [DW-1:0] memwb);
    return sel == FWD_EXMEM ? exmem : sel == FWD_MEMWB ? memwb : reg_val;
  endfunction
endpackage

// File: rtl/ex_alu.sv
// ex_alu: combinational 8-bit ALU
//   A, B       in  operands
//   C          in  current carry flag
//   use_carry  in  add carry / subtract borrow-in from C
//   op         in  ALU operation
//   result     out 8-bit result (wraps modulo 256)
//   carry_out  out carry (ADD), borrow (SUB), shifted-out bit (SHL/SHR), else 0
//   zero       out result == 0
module ex_alu
  import mips_pkg::*;
(
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic          C,
  input  logic          use_carry,
  input  logic [2:0]    op,
  output logic [DW-1:0] result,
  output logic          carry_out,
  output logic          zero
);
  logic [DW:0] r9;
  logic [DW:0] cin;
  assign cin = {{DW{1'b0}}, use_carry & C};
  always_comb begin
    r9 = {1'b0, A};
    case (op)
      OP_ADD:  r9 = {1'b0, A} + {1'b0, B} + cin;
      OP_SUB:  r9 = {1'b0, A} - {1'b0, B} - cin;
      OP_AND:  r9 = {1'b0, A & B};
      OP_OR:   r9 = {1'b0, A | B};
      OP_XOR:  r9 = {1'b0, A ^ B};
      OP_SHL:  r9 = {A, 1'b0};
      OP_SHR:  r9 = {A[0], 1'b0, A[DW-1:1]};
      default: r9 = {1'b0, A};
    endcase
  end
  assign result    = r9[DW-1:0];
  assign carry_out = r9[DW];
  assign zero      = result == '0;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: pipeline execute stage with operand forwarding, C/Z flags and the EX/MEM register
//   clk, reset                       clock, synchronous active-high reset
//   ID_EX_*                          operands, instruction and decoded controls from ID/EX
//   fwd_A_sel, fwd_B_sel             forwarding selects (01 EX/MEM, 10 MEM/WB, else none)
//   MEM_WB_result                    writeback value for forwarding
//   EX_MEM_*                         registered results and pass-through controls
//   carry_flag, zero_flag            architectural flags
//   cond_out                         combinational branch condition (C, Z or 0)
// Forwarding muxes exist only when EX_FORWARDING_EN is defined; otherwise the
// forwarding ports are present but ignored.
module ex_stage
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] ID_EX_A,
  input  logic [DW-1:0] ID_EX_B,
  input  logic [IW-1:0] ID_EX_instruction,
  input  logic          ID_EX_mem_write,
  input  logic          ID_EX_reg_write,
  input  logic          ID_EX_alu_use_carry,
  input  logic          ID_EX_alu_B_mux,
  input  logic          ID_EX_select_c,
  input  logic          ID_EX_select_z,
  input  logic          ID_EX_write_c,
  input  logic          ID_EX_write_z,
  input  logic [2:0]    ID_EX_alu_op,
  input  logic [1:0]    ID_EX_reg_write_mux,
  input  logic [1:0]    fwd_A_sel,
  input  logic [1:0]    fwd_B_sel,
  input  logic [DW-1:0] MEM_WB_result,
  output logic [DW-1:0] EX_MEM_result,
  output logic [DW-1:0] EX_MEM_B,
  output logic [IW-1:0] EX_MEM_instruction,
  output logic          EX_MEM_mem_write,
  output logic          EX_MEM_reg_write,
  output logic [1:0]    EX_MEM_reg_write_mux,
  output logic          carry_flag,
  output logic          zero_flag,
  output logic          cond_out
);
  logic [DW-1:0] op_a, reg_b, op_b, alu_res;
  logic          alu_c, alu_z, carry_d, zero_d, carry_q, zero_q;
  logic [DW-1:0] res_q, b_q;
  logic [IW-1:0] instr_q;
  logic          mw_q, rw_q;
  logic [1:0]    rwm_q;
`ifdef EX_FORWARDING_EN
  assign op_a  = fwd_mux(fwd_A_sel, ID_EX_A, res_q, MEM_WB_result);
  assign reg_b = fwd_mux(fwd_B_sel, ID_EX_B, res_q, MEM_WB_result);
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_A_sel, fwd_B_sel, MEM_WB_result};
  assign op_a  = ID_EX_A;
  assign reg_b = ID_EX_B;
`endif
  assign op_b = ID_EX_alu_B_mux ? ID_EX_instruction[DW-1:0] : reg_b;
  ex_alu u_alu (
    .A         (op_a),
    .B         (op_b),
    .C         (carry_q),
    .use_carry (ID_EX_alu_use_carry),
    .op        (ID_EX_alu_op),
    .result    (alu_res),
    .carry_out (alu_c),
    .zero      (alu_z)
  );
  // NOP never touches the flags, even if the decoder raised write_c/write_z
  always_comb begin
    carry_d = ID_EX_write_c && ID_EX_alu_op != OP_NOP ? alu_c : carry_q;
    zero_d  = ID_EX_write_z && ID_EX_alu_op != OP_NOP ? alu_z : zero_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q   <= '0;
      b_q     <= '0;
      instr_q <= '0;
      mw_q    <= 1'b0;
      rw_q    <= 1'b0;
      rwm_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      res_q   <= alu_res;
      b_q     <= reg_b;
      instr_q <= ID_EX_instruction;
      mw_q    <= ID_EX_mem_write;
      rw_q    <= ID_EX_reg_write;
      rwm_q   <= ID_EX_reg_write_mux;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end
  assign EX_MEM_result        = res_q;
  assign EX_MEM_B             = b_q;
  assign EX_MEM_instruction   = instr_q;
  assign EX_MEM_mem_write     = mw_q;
  assign EX_MEM_reg_write     = rw_q;
  assign EX_MEM_reg_write_mux = rwm_q;
  assign carry_flag           = carry_q;
  assign zero_flag            = zero_q;
  assign cond_out             = ID_EX_select_c ? carry_q : ID_EX_select_z && zero_q;
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: ID_EX_A, ID_EX_B  in  8 each  register operands from the ID/EX register.
REQ-004 SHALL have: ID_EX_instruction  in  19  instruction; bits [7:0] are the immediate.
REQ-005 SHALL have: ID_EX_mem_write, ID_EX_reg_write, ID_EX_alu_use_carry, ID_EX_alu_B_mux, ID_EX_select_c, ID_EX_select_z, ID_EX_write_c, ID_EX_write_z  in  1 each  decoded controls.
REQ-006 SHALL have: ID_EX_alu_op  in  3  ALU operation; ID_EX_reg_write_mux  in  2  writeback source select.
REQ-007 SHALL have: fwd_A_sel, fwd_B_sel  in  2 each  forwarding select (00 none, 01 EX/MEM, 10 MEM/WB, 11 none).
REQ-008 SHALL have: MEM_WB_result  in  8  writeback-stage value for forwarding.
REQ-009 SHALL have: EX_MEM_result, EX_MEM_B  out  8 each  registered ALU result and store data.
REQ-010 SHALL have: EX_MEM_instruction  out  19; EX_MEM_mem_write, EX_MEM_reg_write  out  1 each; EX_MEM_reg_write_mux  out  2  registered pass-through.
REQ-011 SHALL have: carry_flag, zero_flag  out  1 each  architectural C and Z flag registers.
REQ-012 SHALL have: cond_out  out  1  combinational: C if ID_EX_select_c, else Z if ID_EX_select_z, else 0.

Function
REQ-013 Operand A SHALL be ID_EX_A, or forwarded EX_MEM_result (sel 01) or MEM_WB_result (sel 10).
REQ-014 Operand B SHALL be the forwarded register value when ID_EX_alu_B_mux=0, the immediate ID_EX_instruction[7:0] when 1; EX_MEM_B SHALL always take the forwarded register value.
REQ-015 alu_op SHALL decode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOP (result=A, no flag change), 101 XOR, 110 SHL by 1, 111 SHR by 1.
REQ-016 ADD SHALL compute 9-bit A+B+(use_carry?C:0); carry-out = bit 8.
REQ-017 SUB SHALL compute A-B-(use_carry?C:0) in 9 bits; C = borrow (1 when unsigned underflow).
REQ-018 SHL SHALL set C to A[7]; SHR SHALL set C to A[0]; logic ops SHALL produce carry-out 0.
REQ-019 Z candidate SHALL be 1 iff the 8-bit result is 0x00.
REQ-020 C SHALL load carry-out on the edge only when ID_EX_write_c=1; Z likewise with ID_EX_write_z; otherwise hold.
REQ-021 Flags SHALL update one cycle after operand presentation; the next instruction in EX SHALL see updated flags (no flag hazard).
REQ-022 Latency SHALL be exactly one cycle from ID_EX inputs to all EX_MEM outputs; no stall or back-pressure.
REQ-023 A bubble (instruction 0, alu_op 100, write_c=write_z=0) SHALL pass through with no flag change and reg_write/mem_write as presented.
REQ-024 ALU arithmetic SHALL wrap modulo 256 in the 8-bit result.

Reset
REQ-025 reset=1 at an edge SHALL clear all EX_MEM outputs, carry_flag and zero_flag to 0, overriding write_c/write_z in that cycle.
REQ-026 The first instruction after reset deasserts SHALL see C=0, Z=0.

Configuration
REQ-027 Macro EX_FORWARDING_EN defined: forwarding muxes per REQ-013/014 SHALL be present.
REQ-028 Macro EX_FORWARDING_EN undefined: fwd_A_sel, fwd_B_sel and MEM_WB_result SHALL be ignored; operands come only from ID_EX_A/ID_EX_B/immediate; ports remain.

Structure
REQ-029 Shared package mips_pkg SHALL hold ALU opcode constants, data width 8, instruction width 19, forwarding select encodings.
REQ-030 Combinational sub-module ex_alu SHALL implement REQ-015 to REQ-019 (inputs A, B, C, use_carry, op; outputs result, carry_out, zero); ex_stage holds muxes, flags and EX_MEM register.

Verification
REQ-031 ADD A=0xF0, B=0x20, write_c=write_z=1 -> next cycle EX_MEM_result=0x10, C=1, Z=0.
REQ-032 SUB A=0x05, B=0x05, use_carry=1, C=1 -> result=0xFF, C=1, Z=0; repeat with C=0 -> result=0x00, C=0, Z=1.
REQ-033 Back-to-back: ADD writes 0x33 with reg_write; next op fwd_A_sel=01 OR B=0x0C -> result=0x3F (defined) / uses ID_EX_A (undefined).
REQ-034 Bubble (instruction 0, alu_op 100) with C=1, Z=1 -> flags unchanged, EX_MEM_instruction=0.
REQ-035 reset asserted during ADD with write_c=1 -> all outputs 0, C=0, Z=0 next cycle.
REQ-036 select_c=1, C=1 -> cond_out=1 same cycle; select_c=0, select_z=1, Z=0 -> cond_out=0.
